// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port BRAM controller.
// Optional feature macro used by this block: BRAM_SDP_PARITY_EN.
package bram_pkg;

  // Same-address read-during-write policy encodings
  localparam int unsigned RD_READ_FIRST  = 0;
  localparam int unsigned RD_WRITE_FIRST = 1;

  // Upper bound for the width-generic merge helper
  localparam int unsigned BRAM_MAX_W     = 1024;
  localparam int unsigned BRAM_MAX_LANES = BRAM_MAX_W / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bram_state_e;

  // Number of byte lanes in a data word
  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Replace the byte lanes of old_w selected by be with the lanes of new_w
  function automatic logic [BRAM_MAX_W-1:0] be_merge(
    input logic [BRAM_MAX_W-1:0]     old_w,
    input logic [BRAM_MAX_W-1:0]     new_w,
    input logic [BRAM_MAX_LANES-1:0] be
  );
    logic [BRAM_MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(BRAM_MAX_LANES); i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_sdp_ctrl_if.sv
// Write/read/status bundle of the simple-dual-port BRAM controller.
// Optional feature macro: BRAM_SDP_PARITY_EN adds par_err.
interface bram_sdp_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              init_busy;
  logic              collision;
`ifdef BRAM_SDP_PARITY_EN
  logic              par_err;
`endif

  modport master (
`ifdef BRAM_SDP_PARITY_EN
    input  par_err,
`endif
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy, collision
  );

  modport slave (
`ifdef BRAM_SDP_PARITY_EN
    output par_err,
`endif
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy, collision
  );

endinterface

// File: rtl/bram_sdp_core.sv
// Storage array: lane-masked write port, registered read port, no reset.
module bram_sdp_core #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [LANES-1:0]         wbe,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [LANES*LANE_W-1:0]  wdata,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [LANES*LANE_W-1:0]  rdata
);
  localparam int unsigned WORD_W = LANES * LANE_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Read returns the pre-write word on a same-address access
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (wbe[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/bram_sdp_ctrl.sv
// Simple-dual-port BRAM with init sweep, collision policy and output pipeline.
// Optional feature macro: BRAM_SDP_PARITY_EN (per-lane even parity, par_err).
module bram_sdp_ctrl
  import bram_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       OUT_REG  = 0,
  parameter int unsigned       RD_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic           clk,
  input logic           rst_n,
  bram_sdp_ctrl_if.slave bus
);
  localparam int unsigned LANES = lane_count(DATA_W);
  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef BRAM_SDP_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif
  localparam int unsigned WORD_W = LANES * LANE_W;

  // Spread data into storage lanes, adding the lane parity bit when enabled
  function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0] d);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w[i*LANE_W +: 8] = d[i*8 +: 8];
`ifdef BRAM_SDP_PARITY_EN
      w[i*LANE_W + 8] = ^d[i*8 +: 8];
`endif
    end
    return w;
  endfunction

  bram_state_e       state;
  logic [ADDR_W-1:0] cnt;

  logic              run_c, wr_acc_c, rd_acc_c, hit_c;
  logic              core_we;
  logic [LANES-1:0]  core_wbe;
  logic [ADDR_W-1:0] core_waddr;
  logic [WORD_W-1:0] core_wdata, core_q;

  logic              v1, col1, seen1;
  logic [LANES-1:0]  fwd_be1;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] raw_c, data1_c;
`ifdef BRAM_SDP_PARITY_EN
  logic [LANES-1:0]  par_bad_c;
`endif

  // Init sweep FSM: DEPTH cycles of INIT after reset, then RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      cnt           <= '0;
      bus.init_busy <= 1'b1;
    end else if (state == ST_INIT) begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == ADDR_W'(DEPTH - 1)) begin
        state         <= ST_RUN;
        bus.init_busy <= 1'b0;
      end
    end
  end

  // User requests only count in RUN and outside reset
  assign run_c    = rst_n && (state == ST_RUN);
  assign wr_acc_c = run_c && bus.wr_en;
  assign rd_acc_c = run_c && bus.rd_en;
  assign hit_c    = wr_acc_c && rd_acc_c && (bus.rd_addr == bus.wr_addr);

  // Write port mux: sweep owns the port during INIT
  always_comb begin
    core_we    = 1'b0;
    core_wbe   = bus.wr_be;
    core_waddr = bus.wr_addr;
    core_wdata = pack_word(bus.wr_data);
    if (rst_n && (state == ST_INIT)) begin
      core_we    = 1'b1;
      core_wbe   = '1;
      core_waddr = cnt;
      core_wdata = pack_word(INIT_VAL);
    end else if (wr_acc_c) begin
      core_we = 1'b1;
    end
  end

  bram_sdp_core #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .wbe   (core_wbe),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .re    (rd_acc_c),
    .raddr (bus.rd_addr),
    .rdata (core_q)
  );

  // Stage-1 tracking; forward info is held with the read data between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      col1      <= 1'b0;
      seen1     <= 1'b0;
      fwd_be1   <= '0;
      fwd_data1 <= '0;
    end else begin
      v1   <= rd_acc_c;
      col1 <= hit_c;
      if (rd_acc_c) begin
        seen1     <= 1'b1;
        fwd_be1   <= (RD_MODE == RD_WRITE_FIRST && hit_c) ? bus.wr_be : '0;
        fwd_data1 <= bus.wr_data;
      end
    end
  end

  // Unpack storage lanes and check parity on non-forwarded lanes
  always_comb begin
    raw_c = '0;
`ifdef BRAM_SDP_PARITY_EN
    par_bad_c = '0;
`endif
    for (int i = 0; i < int'(LANES); i++) begin
      raw_c[i*8 +: 8] = core_q[i*LANE_W +: 8];
`ifdef BRAM_SDP_PARITY_EN
      par_bad_c[i] = (^core_q[i*LANE_W +: LANE_W]) & ~fwd_be1[i];
`endif
    end
  end

  // Write-first forwarding; zero until the first read after reset
  assign data1_c = seen1 ? DATA_W'(be_merge(BRAM_MAX_W'(raw_c), BRAM_MAX_W'(fwd_data1),
                                            BRAM_MAX_LANES'(fwd_be1)))
                         : '0;

  if (OUT_REG == 0) begin : g_lat1
    assign bus.rd_data   = data1_c;
    assign bus.rd_valid  = v1;
    assign bus.collision = col1;
`ifdef BRAM_SDP_PARITY_EN
    assign bus.par_err   = v1 & (|par_bad_c);
`endif
  end else begin : g_lat2
    // Extra output register stage for latency 2
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bus.rd_data   <= '0;
        bus.rd_valid  <= 1'b0;
        bus.collision <= 1'b0;
`ifdef BRAM_SDP_PARITY_EN
        bus.par_err   <= 1'b0;
`endif
      end else begin
        bus.rd_valid  <= v1;
        bus.collision <= col1;
`ifdef BRAM_SDP_PARITY_EN
        bus.par_err   <= v1 & (|par_bad_c);
`endif
        if (v1) bus.rd_data <= data1_c;
      end
    end
  end

endmodule

// File: tb/tb_bram_sdp_ctrl.sv
// Bench for bram_sdp_ctrl: two configurations driven in lockstep.
// dut_a: latency 1, READ_FIRST, INIT_VAL 0. dut_b: latency 2, WRITE_FIRST, INIT_VAL A5A5A5A5.
// Optional feature macro: BRAM_SDP_PARITY_EN enables the parity backdoor test.
module tb_bram_sdp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;
  bit par_skip = 1'b0;

  always #5 clk = ~clk;

  bram_sdp_ctrl_if #(.DATA_W(32), .ADDR_W(6)) ifa ();
  bram_sdp_ctrl_if #(.DATA_W(32), .ADDR_W(6)) ifb ();

  assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.wr_be = wr_be;   assign ifb.wr_be = wr_be;
  assign ifa.rd_en = rd_en;   assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;

  bram_sdp_ctrl #(.DATA_W(32), .ADDR_W(6), .OUT_REG(0), .RD_MODE(0), .INIT_VAL(32'h0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  bram_sdp_ctrl #(.DATA_W(32), .ADDR_W(6), .OUT_REG(1), .RD_MODE(1), .INIT_VAL(32'hA5A5A5A5))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          d;
    int          due;
    logic [31:0] data;
    bit          col;
  } rd_t;

  rd_t         pend[$];
  logic [31:0] mm [2][64];
  bit          m_busy [2];
  int          m_cnt  [2];
  bit          e_valid[2];
  bit          e_col  [2];
  logic [31:0] e_data [2];
  int          cyc = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] initv(input int d);
    return (d == 0) ? 32'h0 : 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      e_valid[d] = 1'b0;
      e_col[d]   = 1'b0;
    end
    if (!rst_n) begin
      pend.delete();
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 1'b1;
        m_cnt[d]  = 0;
        e_data[d] = 32'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_busy[d]) begin
          mm[d][m_cnt[d]] = initv(d);
          m_cnt[d]++;
          if (m_cnt[d] == 64) m_busy[d] = 1'b0;
        end else begin
          if (rd_en) begin
            rd_t r;
            r.d   = d;
            r.due = cyc + lat(d) - 1;
            r.col = wr_en && (wr_addr == rd_addr);
            r.data = mm[d][rd_addr];
            if (r.col && d == 1) r.data = merge(r.data, wr_data, wr_be);
            pend.push_back(r);
          end
          if (wr_en) mm[d][wr_addr] = merge(mm[d][wr_addr], wr_data, wr_be);
        end
      end
    end
    for (int k = 0; k < pend.size(); ) begin
      if (pend[k].due == cyc) begin
        e_valid[pend[k].d] = 1'b1;
        e_col[pend[k].d]   = pend[k].col;
        e_data[pend[k].d]  = pend[k].data;
        pend.delete(k);
      end else k++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("a_init_busy", 32'(ifa.init_busy), 32'(m_busy[0]));
      chk("a_rd_valid",  32'(ifa.rd_valid),  32'(e_valid[0]));
      chk("a_collision", 32'(ifa.collision), 32'(e_col[0]));
      chk("a_rd_data",   ifa.rd_data,        e_data[0]);
      chk("b_init_busy", 32'(ifb.init_busy), 32'(m_busy[1]));
      chk("b_rd_valid",  32'(ifb.rd_valid),  32'(e_valid[1]));
      chk("b_collision", 32'(ifb.collision), 32'(e_col[1]));
      chk("b_rd_data",   ifb.rd_data,        e_data[1]);
`ifdef BRAM_SDP_PARITY_EN
      if (!par_skip) begin
        chk("a_par_err", 32'(ifa.par_err), 32'h0);
        chk("b_par_err", 32'(ifb.par_err), 32'h0);
      end
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_init(input string nm);
    int na = 0;
    int nb = 0;
    int nv = 0;
    for (int i = 0; i < 200; i++) begin
      if (ifa.init_busy) na++;
      if (ifb.init_busy) nb++;
      if (ifa.rd_valid || ifb.rd_valid) nv++;
      if (!ifa.init_busy && !ifb.init_busy) break;
      tick();
    end
    chk({nm, "_a_busy_cycles"}, 32'(na), 32'd64);
    chk({nm, "_b_busy_cycles"}, 32'(nb), 32'd64);
    chk({nm, "_valid_during_init"}, 32'(nv), 32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int va, vb;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) tick();
    cmp_on = 1'b1;
    chk("reset_a_rd_data", ifa.rd_data, 32'h0);
    chk("reset_b_rd_valid", 32'(ifb.rd_valid), 32'h0);
    rst_n = 1'b1;
    wait_init("init1");

    // Init value visible at the top address
    rd_en = 1'b1; rd_addr = 6'd63;
    tick(); rd_en = 1'b0;
    chk("a_rd63_valid", 32'(ifa.rd_valid), 32'h1);
    chk("a_rd63_data", ifa.rd_data, 32'h0);
    chk("b_rd63_not_yet", 32'(ifb.rd_valid), 32'h0);
    tick();
    chk("b_rd63_valid", 32'(ifb.rd_valid), 32'h1);
    chk("b_rd63_data", ifb.rd_data, 32'hA5A5A5A5);

    // Partial byte-enable write
    wr(6'd5, 32'h11223344, 4'b0101);
    rd_en = 1'b1; rd_addr = 6'd5;
    tick(); rd_en = 1'b0;
    chk("a_be_data", ifa.rd_data, 32'h00220044);
    tick();
    chk("b_be_data", ifb.rd_data, 32'hA522A544);

    // Full-word collision at addr 9 holding zero
    wr(6'd9, 32'h0, 4'hF);
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 6'd9;
    tick(); wr_en = 1'b0; rd_en = 1'b0;
    chk("a_col_data", ifa.rd_data, 32'h0);
    chk("a_col_flag", 32'(ifa.collision), 32'h1);
    tick();
    chk("b_col_data", ifb.rd_data, 32'hDEADBEEF);
    chk("b_col_flag", 32'(ifb.collision), 32'h1);
    chk("a_col_cleared", 32'(ifa.collision), 32'h0);

    // Partial-lane collision at addr 5
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hCAFEF00D; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 6'd5;
    tick(); wr_en = 1'b0; rd_en = 1'b0;
    chk("a_pcol_data", ifa.rd_data, 32'h00220044);
    tick();
    chk("b_pcol_data", ifb.rd_data, 32'hA522F00D);

    // wr_be=0 is a no-op
    wr(6'd5, 32'hFFFFFFFF, 4'h0);
    rd_en = 1'b1; rd_addr = 6'd5;
    tick(); rd_en = 1'b0;
    chk("a_be0_data", ifa.rd_data, 32'h0022F00D);
    tick();

    // Distinct patterns, then back-to-back reads over the whole array
    for (int i = 30; i < 41; i++) wr(6'(i), (32'h01010101 * i) ^ 32'h5A000000, 4'hF);
    va = 0; vb = 0;
    for (int i = 0; i < 66; i++) begin
      rd_en = (i < 64); rd_addr = 6'(i);
      tick();
      if (ifa.rd_valid) va++;
      if (ifb.rd_valid) vb++;
    end
    rd_en = 1'b0;
    chk("a_stream_count", 32'(va), 32'd64);
    chk("b_stream_count", 32'(vb), 32'd64);

    // Reset with reads in flight; user traffic during the re-init is dropped
    rd_en = 1'b1; rd_addr = 6'd1;
    tick();
    rd_addr = 6'd2;
    tick();
    rd_en = 1'b0; rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    tick();
    chk("a_killed", 32'(ifa.rd_valid), 32'h0);
    chk("b_killed", 32'(ifb.rd_valid), 32'h0);
    rst_n = 1'b1; rd_en = 1'b1; rd_addr = 6'd5;
    wait_init("init2");
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    rd_en = 1'b1; rd_addr = 6'd5;
    tick(); rd_en = 1'b0;
    chk("a_reinit_data", ifa.rd_data, 32'h0);
    tick();
    chk("b_reinit_data", ifb.rd_data, 32'hA5A5A5A5);

`ifdef BRAM_SDP_PARITY_EN
    // Flip one stored data bit via backdoor, then one corrupt and one clean read
    wr(6'd20, 32'h12345678, 4'hF);
    tick();
    par_skip = 1'b1;
    dut_a.u_core.mem[20] = dut_a.u_core.mem[20] ^ 36'h8;
    mm[0][20] = mm[0][20] ^ 32'h8;
    rd_en = 1'b1; rd_addr = 6'd20;
    tick();
    rd_addr = 6'd21;
    chk("a_par_err_hit", 32'(ifa.par_err), 32'h1);
    chk("a_par_err_valid", 32'(ifa.rd_valid), 32'h1);
    tick(); rd_en = 1'b0;
    chk("a_par_err_clean", 32'(ifa.par_err), 32'h0);
    tick();
    par_skip = 1'b0;
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_sdp_ctrl.md
Name: bram_sdp_ctrl

Overview:
- Parametrised simple-dual-port block RAM: one write port with byte enables, one read port with a valid-qualified pipelined output.
- Built-in post-reset initialisation sweep clears or presets every word before traffic is accepted.
- Deterministic read-during-write collision handling.
- Drop-in storage primitive for buffers and lookup tables throughout the design; infers FPGA block RAM.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- RD_MODE, 0, same-address collision policy: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new merged data).
- INIT_VAL, 0, DATA_W-bit value written to every word during the init sweep.

Ports:
- clk  in  1  the single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- wr_en  in  1  write strobe; ignored while init_busy=1.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte-lane enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request; ignored while init_busy=1.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; holds the last value between reads.
- rd_valid  out  1  one-cycle pulse marking new rd_data.
- init_busy  out  1  high while the init sweep runs.
- collision  out  1  pulse aligned with rd_valid when that read hit the same address as a concurrent write.
- par_err  out  1  present only with PARITY_EN (see Optional Feature).

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - rd_data=0, rd_valid=0, collision=0, par_err=0.
  - init_busy=1 on the first clock after rst_n rises.
  - Internal sweep counter=0; all pipeline valid bits cleared.
- FSM states: INIT, RUN.
  - rst_n=0 forces INIT with the counter at 0.
  - INIT writes INIT_VAL to address cnt each cycle (all lanes) and increments cnt.
  - After writing DEPTH-1, the FSM moves to RUN. INIT lasts exactly DEPTH cycles.
  - init_busy is 1 in INIT and 0 in RUN.
  - User wr_en/rd_en are dropped in INIT, not queued.
- Reset mid-operation: in-flight reads are discarded (no rd_valid) and the sweep restarts from 0; memory contents are rewritten.
- Write (RUN): when wr_en=1, only lanes with wr_be[i]=1 update at wr_addr. wr_be=0 is a no-op.
- Read (RUN): rd_en=1 samples rd_addr.
  - OUT_REG=0: rd_data/rd_valid update on the next edge (latency 1).
  - OUT_REG=1: they update on the second edge (latency 2).
  - Back-to-back reads every cycle are sustained; throughput is 1 read per cycle.
- Collision: rd_en & wr_en & rd_addr==wr_addr in RUN.
  - RD_MODE=0: returns the pre-write word.
  - RD_MODE=1: returns the old word with enabled lanes replaced by wr_data.
  - In both modes collision pulses with that read's rd_valid.
- Address wrap: none needed; addresses are exactly ADDR_W wide and every value is legal.
- rd_valid is never asserted without a corresponding accepted rd_en.

Optional Feature:
- Macro BRAM_SDP_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, computed from wr_data on write; INIT stores parity of INIT_VAL.
  - On read, parity is recomputed over the returned data.
  - par_err pulses with rd_valid if any lane mismatches; it is 0 on collision-forwarded lanes in WRITE_FIRST mode.
- Undefined: the par_err port and parity storage are absent; storage is DATA_W bits per word.

Decomposition:
- Shared package bram_pkg:
  - RD_MODE encodings RD_READ_FIRST=0, RD_WRITE_FIRST=1.
  - FSM state typedef (ST_INIT, ST_RUN).
  - Function for byte-lane count (DATA_W/8).
  - Byte-enable merge function.
- One natural sub-module, bram_sdp_core: pure storage array with byte-enable write and a registered read, no reset.
- The top holds the init FSM, collision detect/merge, output pipeline and parity.

Test Plan:
- Reset, ADDR_W=6, INIT_VAL=32'hA5A5A5A5 -> init_busy high exactly 64 cycles; a read of address 63 after RUN returns 32'hA5A5A5A5.
- Write 32'h11223344 to addr 5 with wr_be=4'b0101 over INIT_VAL 0 -> a read of addr 5 returns 32'h00220044; rd_valid 1 cycle after rd_en (OUT_REG=0), 2 cycles after (OUT_REG=1).
- Same-cycle write 32'hDEADBEEF (be=4'hF) and read at addr 9 holding 32'h0 -> RD_MODE=0 returns 32'h0, RD_MODE=1 returns 32'hDEADBEEF; collision=1 with that rd_valid only.
- Reads every cycle over addresses 0..63 -> 64 consecutive rd_valid pulses, data in order, no gaps.
- rst_n low for 1 cycle mid-stream with 2 reads in flight -> no rd_valid for them; init_busy reasserts for 64 cycles; wr_en during INIT leaves memory at INIT_VAL.
- With BRAM_SDP_PARITY_EN, force a flip of one stored data bit via the bench backdoor -> par_err=1 with rd_valid on that read; a clean read gives par_err=0.
